// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline stage register.
// Control bit positions and data field offsets match the legacy fixed-field
// stage registers, so downstream decode of ctrl_o/data_o is unchanged.
package pipe_pkg;

    // Control bundle bit indices
    localparam int unsigned REGDST     = 0;
    localparam int unsigned ALUSRC     = 1;
    localparam int unsigned ALUOP_LSB  = 2;   // ALUOP[1:0] occupies bits 3:2
    localparam int unsigned ALUOP_MSB  = 3;
    localparam int unsigned MEMREAD    = 4;
    localparam int unsigned MEMWRITE   = 5;
    localparam int unsigned BRANCH     = 6;
    localparam int unsigned JAL        = 7;
    localparam int unsigned REGWRITE   = 8;
    localparam int unsigned MEMTOREG   = 9;
    localparam int unsigned SLTI       = 10;
    localparam int unsigned SHIFTER    = 11;
    localparam int unsigned MFHI       = 12;
    localparam int unsigned MFLO       = 13;

    localparam int unsigned CTRL_W_DEFAULT = 16;
    localparam int unsigned DATA_W_DEFAULT = 128;

    // Data bundle field offsets (LSB position) and widths
    localparam int unsigned RD1_LSB     = 0;
    localparam int unsigned RD1_W       = 32;
    localparam int unsigned RD2_LSB     = 32;
    localparam int unsigned RD2_W       = 32;
    localparam int unsigned IMM_LSB     = 64;
    localparam int unsigned IMM_W       = 16;
    localparam int unsigned RT_LSB      = 80;
    localparam int unsigned RT_W        = 5;
    localparam int unsigned RD_LSB      = 85;
    localparam int unsigned RD_W        = 5;
    localparam int unsigned FUNCT_LSB   = 90;
    localparam int unsigned FUNCT_W     = 6;
    localparam int unsigned SHAMT_LSB   = 96;
    localparam int unsigned SHAMT_W     = 5;
    // pc_incr is kept as a word address (byte pc bits 28:2)
    localparam int unsigned PC_INCR_LSB = 101;
    localparam int unsigned PC_INCR_W   = 27;

    typedef logic [CTRL_W_DEFAULT-1:0] ctrl_t;

    // No write-enables asserted: safe value for bubbles and reset
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_slot.sv
// One register slot of the stage register: valid, control and data flops.
// Priority per edge is flush > stall > advance; a slot that is not valid
// always carries CTRL_RST so write-enables can never leak downstream.
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int unsigned         CTRL_W   = CTRL_W_DEFAULT,
    parameter int unsigned         DATA_W   = DATA_W_DEFAULT,
    parameter logic [CTRL_W-1:0]   CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_d, valid_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [DATA_W-1:0] data_d, data_q;

    // Next-state selection: flush kills, stall holds, otherwise capture
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_RST;
            // data deliberately held to avoid needless toggling
        end else if (!stall_i) begin
            valid_d = valid_i;
            ctrl_d  = valid_i ? ctrl_i : CTRL_RST;
            data_d  = data_i;
        end
    end

    // Slot flops with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_RST;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slots in series, each
// carrying valid/ctrl/data, with stall, flush and bubble handling.
// Optional performance counters are built when PIPE_STAGE_REG_PERF_EN is
// defined; otherwise stall_cnt_o/flush_cnt_o are tied to zero.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W   = CTRL_W_DEFAULT,
    parameter int unsigned       DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned       DEPTH    = 1,
    parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_NOP)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    input  logic [CTRL_W-1:0]          ctrl_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic                       valid_o,
    output logic [CTRL_W-1:0]          ctrl_o,
    output logic [DATA_W-1:0]          data_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic [31:0]                stall_cnt_o,
    output logic [31:0]                flush_cnt_o
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must be in 1..4");
    end

    logic              valid_s [DEPTH];
    logic [CTRL_W-1:0] ctrl_s  [DEPTH];
    logic [DATA_W-1:0] data_s  [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic              in_valid;
        logic [CTRL_W-1:0] in_ctrl;
        logic [DATA_W-1:0] in_data;

        if (k == 0) begin : g_head
            assign in_valid = valid_i;
            assign in_ctrl  = ctrl_i;
            assign in_data  = data_i;
        end else begin : g_chain
            assign in_valid = valid_s[k-1];
            assign in_ctrl  = ctrl_s[k-1];
            assign in_data  = data_s[k-1];
        end

        pipe_stage_slot #(
            .CTRL_W   (CTRL_W),
            .DATA_W   (DATA_W),
            .CTRL_RST (CTRL_RST)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .stall_i (stall_i),
            .flush_i (flush_i),
            .valid_i (in_valid),
            .ctrl_i  (in_ctrl),
            .data_i  (in_data),
            .valid_o (valid_s[k]),
            .ctrl_o  (ctrl_s[k]),
            .data_o  (data_s[k])
        );
    end

    assign valid_o = valid_s[DEPTH-1];
    assign ctrl_o  = ctrl_s[DEPTH-1];
    assign data_o  = data_s[DEPTH-1];

    logic [OCC_W-1:0] occ_d, occ_q;

    // Occupancy tracks the valid bits the slots will hold after this edge
    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else if (!stall_i) begin
            occ_d = OCC_W'(valid_i);
            for (int k = 0; k < int'(DEPTH) - 1; k++) begin
                occ_d = occ_d + OCC_W'(valid_s[k]);
            end
        end
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy_o = occ_q;

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] flush_cnt_d, flush_cnt_q;

    // Saturating counters: stalls holding a real instruction, effective flushes
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_i && !flush_i && valid_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_i && ((occ_q != '0) || valid_i) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg with DEPTH 1, 2 and 3.
// Instance d2 and d3 use non-zero CTRL_RST values to expose bubble handling.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
    end \
  end

module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int unsigned TimeoutCycles = 2000;

  logic clk;
  logic rst_n;

  // Per-instance inputs: index 0 -> DEPTH 1, 1 -> DEPTH 2, 2 -> DEPTH 3
  logic         stall [3];
  logic         flush [3];
  logic         vin   [3];
  logic [15:0]  cin   [3];
  logic [127:0] din   [3];

  logic         v1, v2, v3;
  logic [15:0]  c1, c2, c3;
  logic [127:0] o1, o2, o3;
  logic [0:0]   occ1;
  logic [1:0]   occ2, occ3;
  logic [31:0]  sc1, sc2, sc3, fc1, fc2, fc3;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .DEPTH(1), .CTRL_RST(16'h0000)) u_d1 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall[0]), .flush_i(flush[0]),
    .valid_i(vin[0]), .ctrl_i(cin[0]), .data_i(din[0]),
    .valid_o(v1), .ctrl_o(c1), .data_o(o1), .occupancy_o(occ1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .DEPTH(2), .CTRL_RST(16'h8000)) u_d2 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall[1]), .flush_i(flush[1]),
    .valid_i(vin[1]), .ctrl_i(cin[1]), .data_i(din[1]),
    .valid_o(v2), .ctrl_o(c2), .data_o(o2), .occupancy_o(occ2),
    .stall_cnt_o(sc2), .flush_cnt_o(fc2)
  );

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .DEPTH(3), .CTRL_RST(16'h4000)) u_d3 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall[2]), .flush_i(flush[2]),
    .valid_i(vin[2]), .ctrl_i(cin[2]), .data_i(din[2]),
    .valid_o(v3), .ctrl_o(c3), .data_o(o3), .occupancy_o(occ3),
    .stall_cnt_o(sc3), .flush_cnt_o(fc3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every instance must show its reset values on all outputs
  task automatic check_reset(input string tag);
    checks++;
    if (v1 !== 1'b0 || c1 !== 16'h0000 || o1 !== 128'h0 || occ1 !== 1'b0 ||
        v2 !== 1'b0 || c2 !== 16'h8000 || o2 !== 128'h0 || occ2 !== 2'd0 ||
        v3 !== 1'b0 || c3 !== 16'h4000 || o3 !== 128'h0 || occ3 !== 2'd0 ||
        sc1 !== 32'd0 || sc2 !== 32'd0 || sc3 !== 32'd0 ||
        fc1 !== 32'd0 || fc2 !== 32'd0 || fc3 !== 32'd0) begin
      errors++;
      $error("FAIL %s: outputs not at reset values", tag);
    end
  endtask

  // Watchdog: the directed sequence must complete in bounded time
  initial begin
    repeat (TimeoutCycles) @(posedge clk);
    if (!done) begin
      errors++;
      $error("FAIL timeout: sequence did not finish within %0d cycles", TimeoutCycles);
      $finish;
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stall[i] = 1'b0;
      flush[i] = 1'b0;
      vin[i]   = 1'b0;
      cin[i]   = 16'h0000;
      din[i]   = 128'h0;
    end
    #12;

    // Reset state
    check_reset("rst_all");
    `CHK("rst_v1", v1, 1'b0)
    `CHK("rst_c1", c1, 16'h0000)
    `CHK("rst_c2", c2, 16'h8000)
    `CHK("rst_c3", c3, 16'h4000)
    `CHK("rst_o2", o2, 128'h0)
    `CHK("rst_occ3", occ3, 2'd0)
    `CHK("rst_sc1", sc1, 32'd0)
    `CHK("rst_fc3", fc3, 32'd0)
    rst_n = 1'b1;

    // Streaming through DEPTH=2
    vin[1] = 1'b1; cin[1] = 16'h00A5; din[1] = 128'h1;
    tick();
    `CHK("s_e1_v2", v2, 1'b0)
    `CHK("s_e1_c2", c2, 16'h8000)
    `CHK("s_e1_occ2", occ2, 2'd1)
    cin[1] = 16'h00A6; din[1] = 128'h2;
    tick();
    `CHK("s_e2_v2", v2, 1'b1)
    `CHK("s_e2_c2", c2, 16'h00A5)
    `CHK("s_e2_o2", o2, 128'h1)
    `CHK("s_e2_occ2", occ2, 2'd2)
    cin[1] = 16'h00A7; din[1] = 128'h3;
    tick();
    `CHK("s_e3_c2", c2, 16'h00A6)
    `CHK("s_e3_o2", o2, 128'h2)
    `CHK("s_e3_occ2", occ2, 2'd2)

    // Bubble insertion: invalid entry with all control bits set
    vin[1] = 1'b0; cin[1] = 16'hFFFF; din[1] = 128'hBB;
    tick();
    `CHK("b_e1_c2", c2, 16'h00A7)
    `CHK("b_e1_occ2", occ2, 2'd1)
    tick();
    `CHK("b_e2_v2", v2, 1'b0)
    `CHK("b_e2_c2", c2, 16'h8000)
    `CHK("b_e2_o2", o2, 128'hBB)
    `CHK("b_e2_occ2", occ2, 2'd0)

    // Stall hold on DEPTH=1 (legacy single-cycle timing first)
    vin[0] = 1'b1; cin[0] = 16'h0011; din[0] = 128'h11;
    tick();
    `CHK("st_cap_c1", c1, 16'h0011)
    `CHK("st_cap_o1", o1, 128'h11)
    `CHK("st_cap_occ1", occ1, 1'b1)
    stall[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cin[0] = 16'h0022 + 16'(i);
      din[0] = 128'h22 + 128'(i);
      tick();
      `CHK("st_hold_c1", c1, 16'h0011)
      `CHK("st_hold_o1", o1, 128'h11)
      `CHK("st_hold_v1", v1, 1'b1)
    end
    `CHK("st_cnt1", sc1, (PERF ? 32'd3 : 32'd0))
`ifdef PIPE_STAGE_REG_PERF_EN
    // Saturation: preload near the top, then three more stalls
    @(negedge clk);
    u_d1.stall_cnt_q = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) tick();
    `CHK("sat_sc1", sc1, 32'hFFFF_FFFF)
    `CHK("sat_hold_c1", c1, 16'h0011)
`endif
    stall[0] = 1'b0; cin[0] = 16'h0055; din[0] = 128'h55;
    tick();
    `CHK("st_rel_c1", c1, 16'h0055)
    `CHK("st_rel_o1", o1, 128'h55)
    vin[0] = 1'b0;

    // Flush beats stall on DEPTH=3
    vin[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cin[2] = 16'h00C1 + 16'(i);
      din[2] = 128'hC1 + 128'(i);
      tick();
      if (i == 0) begin
        `CHK("f_e1_c3", c3, 16'h4000)
      end
    end
    `CHK("f_full_c3", c3, 16'h00C1)
    `CHK("f_full_occ3", occ3, 2'd3)
    stall[2] = 1'b1; cin[2] = 16'h00C4; din[2] = 128'hC4;
    tick();
    `CHK("f_hold_c3", c3, 16'h00C1)
    `CHK("f_hold_occ3", occ3, 2'd3)
    flush[2] = 1'b1; cin[2] = 16'hFFFF; din[2] = 128'hEE;
    tick();
    `CHK("f_v3", v3, 1'b0)
    `CHK("f_c3", c3, 16'h4000)
    `CHK("f_o3", o3, 128'hC1)
    `CHK("f_occ3", occ3, 2'd0)
    `CHK("f_fc3", fc3, (PERF ? 32'd1 : 32'd0))
    flush[2] = 1'b0; stall[2] = 1'b0; vin[2] = 1'b0; din[2] = 128'hD0;
    tick();
    `CHK("f_adv_v3", v3, 1'b0)
    `CHK("f_adv_c3", c3, 16'h4000)
    `CHK("f_adv_o3", o3, 128'hC2)
    // Flushing an empty register with no incoming entry is not counted
    flush[2] = 1'b1;
    tick();
    `CHK("f_empty_fc3", fc3, (PERF ? 32'd1 : 32'd0))
    `CHK("f_empty_o3", o3, 128'hC2)
    flush[2] = 1'b0;

    // Asynchronous reset mid-stream on DEPTH=2
    vin[1] = 1'b1; cin[1] = 16'h0077; din[1] = 128'h77;
    tick();
    cin[1] = 16'h0078; din[1] = 128'h78;
    tick();
    `CHK("r_pre_c2", c2, 16'h0077)
    `CHK("r_pre_occ2", occ2, 2'd2)
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("r_all");
    `CHK("r_v2", v2, 1'b0)
    `CHK("r_c2", c2, 16'h8000)
    `CHK("r_o2", o2, 128'h0)
    `CHK("r_occ2", occ2, 2'd0)
    `CHK("r_sc1", sc1, 32'd0)
    tick();
    `CHK("r_held_v2", v2, 1'b0)
    `CHK("r_held_c2", c2, 16'h8000)
    rst_n = 1'b1;
    vin[1] = 1'b0;
    tick();
    `CHK("r_idle_v2", v2, 1'b0)
    `CHK("r_idle_occ2", occ2, 2'd0)
    vin[1] = 1'b1; cin[1] = 16'h0099; din[1] = 128'h99;
    tick();
    `CHK("r_new1_v2", v2, 1'b0)
    tick();
    `CHK("r_new2_v2", v2, 1'b1)
    `CHK("r_new2_c2", c2, 16'h0099)
    `CHK("r_new2_o2", o2, 128'h99)

    done = 1'b1;
    if (errors != 0) begin
      $error("FAIL summary: %0d of %0d checks failed", errors, checks);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register; successor to the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a packed control bundle and a packed data bundle through DEPTH back-to-back register slots, each with a valid bit.
- Supports stall (hold), flush (bubble insertion) and asynchronous reset.
- Sits between any two CPU pipeline stages. The hazard unit drives stall_i and flush_i.

Parameters:
- CTRL_W, 16, width of packed control bundle (EX/M/WB signals).
- DATA_W, 128, width of packed data bundle (operands, immediates, reg indices, pc_incr).
- DEPTH, 1, number of register slots in series; legal 1..4.
- CTRL_RST, 0, control value loaded on reset, flush and bubble; all write-enables deasserted.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hold all slots this cycle.
- flush_i  input  1  kill all slots and the incoming entry this cycle.
- valid_i  input  1  incoming entry is a real instruction.
- ctrl_i  input  CTRL_W  incoming control bundle.
- data_i  input  DATA_W  incoming data bundle.
- valid_o  output  1  last slot holds a real instruction.
- ctrl_o  output  CTRL_W  last-slot control.
- data_o  output  DATA_W  last-slot data.
- occupancy_o  output  $clog2(DEPTH+1)  count of valid slots.
- stall_cnt_o  output  32  stall-cycle counter (optional feature).
- flush_cnt_o  output  32  effective-flush counter (optional feature).

Behaviour:
- Reset, asynchronous on rst_n=0, effective immediately (including mid-operation):
  - every slot: valid=0, ctrl=CTRL_RST, data=0.
  - valid_o=0, ctrl_o=CTRL_RST, data_o=0, occupancy_o=0, counters=0.
- All outputs are driven directly from the last slot's flops. No combinational path from any input to any output.
- Latency: an entry accepted at edge N appears on the outputs after edge N+DEPTH-1, given no stalls.
- Per rising edge, priority is flush > stall > advance:
  - flush_i=1: every slot gets valid=0, ctrl=CTRL_RST; data holds its current value (power saving). The incoming entry is discarded. flush_i=1 together with stall_i=1 behaves as a flush.
  - stall_i=1, flush_i=0: every slot holds valid/ctrl/data. The incoming entry is not captured; upstream must hold it.
  - Otherwise (advance): slot k <= slot k-1 and slot 0 <= incoming entry.
    - If valid_i=0, slot 0 gets ctrl=CTRL_RST and valid=0; data is captured anyway.
    - Bubble rule: a slot with valid=0 always carries ctrl==CTRL_RST, so RegWrite/MemWrite can never leak downstream.
- occupancy_o: registered popcount of slot valid bits, updated in the same edge as the slots. Range 0..DEPTH. After a flush it is 0.
- DEPTH=1 must reproduce the legacy stage-register timing exactly when stall_i=flush_i=0 and valid_i=1.
- DEPTH outside 1..4: elaboration-time error.

Optional Feature:
- Macro PIPE_STAGE_REG_PERF_EN.
- Defined:
  - stall_cnt_o increments on each edge with stall_i=1, flush_i=0 and valid_o=1.
  - flush_cnt_o increments on each edge with flush_i=1 and (occupancy_o!=0 or valid_i=1).
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: no counter flops; both ports are tied to 0. The port list is unchanged.

Decomposition:
- Package pipe_pkg holds:
  - CTRL bit-index localparams (REGDST, ALUSRC, ALUOP[1:0], MEMREAD, MEMWRITE, BRANCH, JAL, REGWRITE, MEMTOREG, SLTI, SHIFTER, MFHI, MFLO).
  - CTRL_W_DEFAULT and DATA field offsets (RD1, RD2, IMM, RT, RD, FUNCT, SHAMT, PC_INCR).
  - typedef ctrl_t.
  - CTRL_NOP constant.
- Sub-module pipe_stage_slot: one slot (valid/ctrl/data, with the flush/stall/bubble rules). Instantiated DEPTH times through a generate loop; the occupancy and counter logic sits in the top.

Test Plan:
- Reset then stream, DEPTH=2: valid_i=1, ctrl_i=16'h00A5, data_i=128'h1 at edge 1 -> ctrl_o=16'h00A5, data_o=1, valid_o=1 after edge 2; occupancy_o=2 during continuous streaming.
- Stall hold, DEPTH=1: entry X captured, then stall_i=1 for 3 edges with changing inputs -> outputs stay X for all 3; no new capture; stall_cnt_o=3 when PIPE_STAGE_REG_PERF_EN is defined.
- Flush beats stall, DEPTH=3: 3 valid entries held, then flush_i=stall_i=1 -> next edge valid_o=0, ctrl_o=CTRL_RST, occupancy_o=0, data_o unchanged; flush_cnt_o=1.
- Bubble insertion: valid_i=0 with ctrl_i=16'hFFFF -> the slot emerges with ctrl_o=CTRL_RST, valid_o=0.
- Async reset mid-stream: rst_n low between edges while full -> outputs clear before the next edge and stay cleared until rst_n=1 and a fresh entry arrives.
- Counter saturation (PERF_EN, with the counter force-loaded to 32'hFFFF_FFFE): 3 stall cycles -> stall_cnt_o ends at 32'hFFFF_FFFF with no wrap.
